// File: rtl/mips_mem_pkg.sv
// Memory-side definitions shared by the store formatter and the load-side extractor:
// size encodings, byte-lane constants, the store entry layout and lane-mapping helpers.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    // Little-endian lanes: lane i is bits [8i+7:8i], selected by addr[1:0] == i.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_LANE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

    function automatic logic store_misaligned(input mem_size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_wdata(input mem_size_e size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_LANE0 << off;
            SZ_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; full/empty derived from the occupancy counter.
// Latency: a push is visible at dout the cycle after the write edge.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/store_formatter.sv
// Narrows sb/sh/sw requests to lane-replicated data + byte enables and queues them for memory.
// Latency: 1 cycle from accept to mem_valid (no bypass); misalign pulses the cycle after accept.
// Backpressure: req_ready = !full (no ready-from-pop path); mem side is valid/ready.
module store_formatter
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_size,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [31:0]                req_data,
    output logic                       misalign,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int ENT_W = ADDR_W + 32 + 4;

    mem_size_e         size;
    logic              accept;
    logic              bad;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [31:0]       fmt_wdata;
    logic [3:0]        fmt_be;
    logic [ADDR_W-1:0] fmt_addr;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_ent;
    logic [3:0]        head_be;
    logic              misalign_q, misalign_d;

    always_comb begin
        size      = mem_size_e'(req_size);
        accept    = req_valid && req_ready;
        bad       = store_misaligned(size, req_addr[1:0]);
        push      = accept && !bad;
        fmt_wdata = store_wdata(size, req_data);
        fmt_be    = store_be(size, req_addr[1:0]);
        fmt_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        push_ent  = {fmt_addr, fmt_wdata, fmt_be};
        // A rejected request still completes its handshake; it only raises the pulse.
        misalign_d = accept && bad;
        pop        = mem_valid && mem_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head_ent),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign req_ready = !full;
    assign misalign  = misalign_q;
    assign mem_valid = !empty;
    assign {mem_addr, mem_wdata, head_be} = head_ent;
    // Stale storage may sit at the head when empty; never let it enable a lane.
    assign mem_be = mem_valid ? head_be : BE_NONE;

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: formatting, misalign drops, full/backpressure, wrap, async reset.
module tb_store_formatter;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        misalign;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    store_formatter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .misalign  (misalign),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_size  = sz;
        req_addr  = a;
        req_data  = d;
    endtask

    task automatic head(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd1);
        chk({tag, ".addr"},  64'(mem_addr),  64'(a));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(w));
        chk({tag, ".be"},    64'(mem_be),    64'(be));
    endtask

    logic [31:0] seq_addr [10];
    logic [31:0] seq_data [10];

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_size  = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        mem_ready = 1'b0;
        #3;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.mem_valid", 64'(mem_valid), 64'd0);
        chk("rst.mem_be",    64'(mem_be),    64'd0);
        chk("rst.misalign",  64'(misalign),  64'd0);
        chk("rst.count",     64'(count),     64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Byte store to lane 3; no same-cycle bypass
        drive(2'b00, 32'h0000_1003, 32'h0000_00A5);
        #1;
        chk("byte.no_bypass", 64'(mem_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        head("byte", 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        chk("byte.count", 64'(count), 64'd1);
        mem_ready = 1'b1;
        tick();
        chk("byte.popped", 64'(mem_valid), 64'd0);
        chk("byte.be_gated", 64'(mem_be), 64'd0);
        mem_ready = 1'b0;

        // Upper halfword
        drive(2'b01, 32'h0000_2002, 32'hFFFF_1234);
        tick();
        req_valid = 1'b0;
        head("half", 32'h0000_2000, 32'h1234_1234, 4'b1100);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // Lower halfword
        drive(2'b01, 32'h0000_2000, 32'h0000_BEEF);
        tick();
        req_valid = 1'b0;
        head("half_lo", 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // Word
        drive(2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        head("word", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
        mem_ready = 1'b1;
        tick();
        chk("word.popped", 64'(count), 64'd0);
        mem_ready = 1'b0;

        // Misaligned half, misaligned word, reserved size
        drive(2'b01, 32'h0000_0011, 32'h1);
        tick();
        req_valid = 1'b0;
        chk("mis_half.pulse", 64'(misalign),  64'd1);
        chk("mis_half.count", 64'(count),     64'd0);
        chk("mis_half.valid", 64'(mem_valid), 64'd0);
        tick();
        chk("mis_half.one_cycle", 64'(misalign), 64'd0);
        drive(2'b10, 32'h0000_0022, 32'h2);
        tick();
        req_valid = 1'b0;
        chk("mis_word.pulse", 64'(misalign),  64'd1);
        chk("mis_word.count", 64'(count),     64'd0);
        tick();
        chk("mis_word.one_cycle", 64'(misalign), 64'd0);
        drive(2'b11, 32'h0000_0000, 32'h3);
        tick();
        req_valid = 1'b0;
        chk("mis_rsvd.pulse", 64'(misalign),  64'd1);
        chk("mis_rsvd.valid", 64'(mem_valid), 64'd0);
        tick();
        chk("mis_rsvd.one_cycle", 64'(misalign), 64'd0);

        // Fill to full with memory stalled
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
            tick();
        end
        chk("full.req_ready", 64'(req_ready), 64'd0);
        chk("full.count",     64'(count),     64'd4);
        drive(2'b10, 32'h110, 32'h1111_0004);
        tick();
        chk("full.blocked_count", 64'(count), 64'd4);
        head("full.stable", 32'h100, 32'h1111_0000, 4'b1111);
        mem_ready = 1'b1;
        tick();
        chk("full.pop_only_count", 64'(count), 64'd3);
        chk("full.ready_after_pop", 64'(req_ready), 64'd1);
        head("full.h1", 32'h104, 32'h1111_0001, 4'b1111);
        tick();
        req_valid = 1'b0;
        chk("full.fifth_in", 64'(count), 64'd3);
        head("full.h2", 32'h108, 32'h1111_0002, 4'b1111);
        tick();
        head("full.h3", 32'h10C, 32'h1111_0003, 4'b1111);
        tick();
        head("full.h4", 32'h110, 32'h1111_0004, 4'b1111);
        tick();
        chk("full.drained", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;

        // Concurrent push/pop at occupancy 2
        for (int k = 0; k < 10; k++) begin
            seq_addr[k] = 32'h200 + 32'(4 * k);
            seq_data[k] = 32'h2222_0000 + 32'(k);
        end
        drive(2'b10, seq_addr[0], seq_data[0]);
        tick();
        drive(2'b10, seq_addr[1], seq_data[1]);
        tick();
        chk("cc.count_start", 64'(count), 64'd2);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'b10, seq_addr[i + 2], seq_data[i + 2]);
            tick();
            chk($sformatf("cc.count%0d", i), 64'(count), 64'd2);
            chk($sformatf("cc.addr%0d", i), 64'(mem_addr), 64'(seq_addr[i + 1]));
            chk($sformatf("cc.data%0d", i), 64'(mem_wdata), 64'(seq_data[i + 1]));
        end
        req_valid = 1'b0;
        head("cc.tail0", seq_addr[8], seq_data[8], 4'b1111);
        tick();
        head("cc.tail1", seq_addr[9], seq_data[9], 4'b1111);
        tick();
        chk("cc.empty", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;

        // Asynchronous reset mid-operation with a pending misalign pulse
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 32'h300 + 32'(4 * i), 32'h3333_0000 + 32'(i));
            tick();
        end
        drive(2'b10, 32'h302, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("pre_rst.count",    64'(count),     64'd3);
        chk("pre_rst.valid",    64'(mem_valid), 64'd1);
        chk("pre_rst.misalign", 64'(misalign),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid",     64'(mem_valid), 64'd0);
        chk("arst.be",        64'(mem_be),    64'd0);
        chk("arst.count",     64'(count),     64'd0);
        chk("arst.req_ready", 64'(req_ready), 64'd1);
        chk("arst.misalign",  64'(misalign),  64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst.empty", 64'(mem_valid), 64'd0);
        drive(2'b10, 32'h0000_4000, 32'hCAFE_F00D);
        tick();
        req_valid = 1'b0;
        chk("post_rst.count", 64'(count), 64'd1);
        head("post_rst", 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
        mem_ready = 1'b1;
        tick();
        chk("post_rst.alone", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
